// File: rtl/diff_demo_pkg.sv
// Shared types and defaults for the write-back scheduler.
package diff_demo_pkg;

  localparam int FM_ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BANK,
    S_ISSUE,
    S_RUN,
    S_RELEASE,
    S_DONE
  } wb_state_t;

endpackage

// File: rtl/wb_scheduler.sv
// Write-back scheduler: walks the channels of a layer, waiting on the
// expected psum ping-pong bank, issuing one write-back per channel,
// counting written bytes to advance the feature-map base address and
// releasing the bank when write-back reports completion.
module wb_scheduler
  import diff_demo_pkg::*;
#(
  parameter int FM_ADDR_W = FM_ADDR_W_DEF,
  parameter int BANKS     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [7:0]           cfg_ch_num,
  input  logic [7:0]           cfg_w_num,
  input  logic [7:0]           cfg_h_num,
  input  logic [7:0]           cfg_w_cut,
  input  logic                 cfg_is_diff,
  input  logic [BANKS-1:0]     bank_full,
  output logic [BANKS-1:0]     bank_release,
  output logic                 wb_ctrl_valid,
  input  logic                 wb_ctrl_ready,
  input  logic                 wb_ctrl_finish,
  output logic [7:0]           wb_w_num_o,
  output logic [7:0]           wb_h_num_o,
  output logic [7:0]           wb_w_cut_o,
  output logic                 wb_is_diff_o,
  output logic                 wb_bank_sel,
  input  logic                 wb_data_valid,
  output logic [FM_ADDR_W-1:0] fm_base_addr,
  output logic [7:0]           ch_idx,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 cfg_err
);

  wb_state_t            state_q, state_d;
  logic [7:0]           ch_num_q;
  logic [FM_ADDR_W-1:0] byte_cnt;
  logic                 exp_bank;
  logic                 accept;
  logic                 cfg_bad;
  logic [7:0]           ch_next;

  assign accept      = (state_q == S_IDLE) && cfg_valid;
  assign cfg_bad     = (cfg_w_num == 8'd0) || (cfg_h_num == 8'd0);
  assign ch_next     = ch_idx + 8'd1;
  assign wb_bank_sel = exp_bank;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_d       = state_q;
    cfg_ready     = 1'b0;
    busy          = 1'b1;
    wb_ctrl_valid = 1'b0;
    bank_release  = '0;
    layer_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) begin
          // A malformed window leaves the scheduler idle; it only flags cfg_err.
          if (cfg_bad)                state_d = S_IDLE;
          else if (cfg_ch_num == 8'd0) state_d = S_DONE;
          else                         state_d = S_WAIT_BANK;
        end
      end
      S_WAIT_BANK: begin
        if (bank_full[exp_bank]) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wb_ctrl_valid = 1'b1;
        if (wb_ctrl_ready) state_d = S_RUN;
      end
      S_RUN: begin
        if (wb_ctrl_finish) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        bank_release[exp_bank] = 1'b1;
        state_d = (ch_next == ch_num_q) ? S_DONE : S_WAIT_BANK;
      end
      S_DONE: begin
        layer_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Config latch, channel/address bookkeeping and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_num_q     <= '0;
      wb_w_num_o   <= '0;
      wb_h_num_o   <= '0;
      wb_w_cut_o   <= '0;
      wb_is_diff_o <= 1'b0;
      byte_cnt     <= '0;
      fm_base_addr <= '0;
      ch_idx       <= '0;
      exp_bank     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= accept && cfg_bad;
      if (accept) begin
        ch_num_q     <= cfg_ch_num;
        wb_w_num_o   <= cfg_w_num;
        wb_h_num_o   <= cfg_h_num;
        wb_w_cut_o   <= cfg_w_cut;
        wb_is_diff_o <= cfg_is_diff;
        byte_cnt     <= '0;
        fm_base_addr <= '0;
        ch_idx       <= '0;
        exp_bank     <= 1'b0;
      end
      if (state_q == S_RUN && wb_data_valid) begin
        byte_cnt <= byte_cnt + FM_ADDR_W'(1);
      end
      if (state_q == S_RELEASE) begin
        fm_base_addr <= fm_base_addr + byte_cnt;
        byte_cnt     <= '0;
        exp_bank     <= ~exp_bank;
        ch_idx       <= ch_next;
      end
    end
  end

endmodule
